demux_pair_capture: RTL and testbench
=====================================

// Module: demux_pair_capture
// PURPOSE
//  Inverse of the 2:1 byte selector. Takes a time-multiplexed W-bit bus tagged by a select bit.
//  Routes each valid word into one of two holding registers: X (sel=0) or Y (sel=1).
//  Once both an X and a Y word have been captured, it presents them as a pair.
//  The pair is held under a valid/ack handshake; any traffic that does not fit is flagged as overrun.
//  Sits between a shared switch/serial bus and the LEDR/LEDG display or downstream compare logic.
// PARAMETERS
//  W      8   data width of din, x_q, y_q
//  CNT_W  8   width of pair_count (wraps modulo 2**CNT_W)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  din         in   W       multiplexed data word
//  sel         in   1       0 = word belongs to X, 1 = word belongs to Y
//  din_valid   in   1       one-cycle qualifier for din/sel
//  pair_ack    in   1       consumer accepts the presented pair
//  ovr_clr     in   1       clears sticky overrun
//  x_q         out  W       last captured X word
//  y_q         out  W       last captured Y word
//  pair_valid  out  1       X and Y both fresh; held until pair_ack
//  overrun     out  1       sticky error flag
//  pair_count  out  CNT_W   number of acknowledged pairs
//  state_q     out  2       FSM state: 0 IDLE, 1 GOT_X, 2 GOT_Y, 3 PAIR
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state IDLE; x_q, y_q, pair_count = 0; pair_valid = 0; overrun = 0.
//  Outputs:
//   - All outputs are registered.
//   - pair_valid = (state_q == PAIR).
//  Capture:
//   - A word accepted on cycle N appears on x_q/y_q after edge N+1.
//   - A register is written only on an accepted word of its own channel; otherwise it holds.
//   - x_q/y_q are NOT cleared on ack.
//  FSM (evaluated only when din_valid=1, unless noted; "+ovr" means overrun <= 1):
//   - IDLE:  sel=0 -> capture X, go GOT_X.  sel=1 -> capture Y, go GOT_Y.
//   - GOT_X: sel=1 -> capture Y, go PAIR.   sel=0 -> overwrite X, stay, +ovr.
//   - GOT_Y: sel=0 -> capture X, go PAIR.   sel=1 -> overwrite Y, stay, +ovr.
//   - PAIR, pair_ack=0: word dropped, x_q/y_q unchanged, stay, +ovr.
//   - PAIR, pair_ack=1 (checked regardless of din_valid):
//       pair_count += 1 (wraps to 0 from all-ones).
//       No din_valid: go IDLE.
//       Same-cycle din_valid: word processed exactly as in IDLE (goes GOT_X/GOT_Y, no ovr).
//  pair_ack outside PAIR is ignored.
//  overrun is sticky, cleared by ovr_clr. If ovr_clr coincides with a new overrun event, set wins.
//  Reset asserted mid-operation discards any partial or pending pair immediately.
// TESTING
//  1. Reset; valid X=0x3C then Y=0xA5 -> pair_valid=1 two edges after X; x_q=3C, y_q=A5; overrun=0.
//  2. From 1, assert pair_ack one cycle -> state IDLE, pair_valid=0, pair_count=1, x_q/y_q hold.
//  3. Y=0x11, Y=0x22, X=0x33 -> overrun=1 after 2nd word; pair y_q=22, x_q=33; ovr_clr -> overrun=0.
//  4. In PAIR, send X=0x55 with ack=0 -> dropped (x_q unchanged), overrun=1; X=0x66 with ack=1 -> GOT_X, x_q=66.
//  5. Complete and ack 256 pairs (CNT_W=8) -> pair_count wraps to 0; ovr_clr coincident with overwrite -> overrun stays 1.
//  6. Assert rst between X and Y words -> outputs all 0 asynchronously; next Y alone -> GOT_Y, no pair_valid.

Source files
------------

// File: rtl/demux_pair_capture.sv
// demux_pair_capture: steers a select-tagged, time-multiplexed bus into X/Y
// holding registers and presents each completed X/Y pair under valid/ack.
module demux_pair_capture #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     din,
  input  logic             sel,
  input  logic             din_valid,
  input  logic             pair_ack,
  input  logic             ovr_clr,
  output logic [W-1:0]     x_q,
  output logic [W-1:0]     y_q,
  output logic             pair_valid,
  output logic             overrun,
  output logic [CNT_W-1:0] pair_count,
  output logic [1:0]       state_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_X = 2'd1,
    GOT_Y = 2'd2,
    PAIR  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_x;
  logic [W-1:0]     r_y;
  logic             r_pair_valid;
  logic             r_overrun;
  logic [CNT_W-1:0] r_count;
  logic             w_cap_x;
  logic             w_cap_y;
  logic             w_ovr_set;
  logic             w_cnt_inc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state, capture enables, overrun events and pair-count increment
  always_comb begin
    w_next    = r_state;
    w_cap_x   = 1'b0;
    w_cap_y   = 1'b0;
    w_ovr_set = 1'b0;
    w_cnt_inc = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (din_valid) begin
          if (sel) begin w_cap_y = 1'b1; w_next = GOT_Y; end
          else     begin w_cap_x = 1'b1; w_next = GOT_X; end
        end
      end
      GOT_X: begin
        if (din_valid) begin
          if (sel) begin w_cap_y = 1'b1; w_next = PAIR; end
          else     begin w_cap_x = 1'b1; w_ovr_set = 1'b1; end
        end
      end
      GOT_Y: begin
        if (din_valid) begin
          if (!sel) begin w_cap_x = 1'b1; w_next = PAIR; end
          else      begin w_cap_y = 1'b1; w_ovr_set = 1'b1; end
        end
      end
      PAIR: begin
        if (pair_ack) begin
          // An ack frees the pair; a same-cycle word starts the next pair as from IDLE.
          w_cnt_inc = 1'b1;
          if (din_valid) begin
            if (sel) begin w_cap_y = 1'b1; w_next = GOT_Y; end
            else     begin w_cap_x = 1'b1; w_next = GOT_X; end
          end else begin
            w_next = IDLE;
          end
        end else if (din_valid) begin
          w_ovr_set = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Holding registers, registered pair_valid, sticky overrun and pair counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_pair_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_count      <= '0;
    end else begin
      if (w_cap_x) r_x <= din;
      if (w_cap_y) r_y <= din;
      r_pair_valid <= (w_next == PAIR);
      if (w_ovr_set)    r_overrun <= 1'b1;
      else if (ovr_clr) r_overrun <= 1'b0;
      if (w_cnt_inc) r_count <= r_count + 1'b1;
    end
  end

  assign x_q        = r_x;
  assign y_q        = r_y;
  assign pair_valid = r_pair_valid;
  assign overrun    = r_overrun;
  assign pair_count = r_count;
  assign state_q    = r_state;

endmodule

// File: tb/tb_demux_pair_capture.sv
// Directed self-checking bench for demux_pair_capture.
module tb_demux_pair_capture;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       sel;
  logic       din_valid;
  logic       pair_ack;
  logic       ovr_clr;
  logic [7:0] x_q;
  logic [7:0] y_q;
  logic       pair_valid;
  logic       overrun;
  logic [7:0] pair_count;
  logic [1:0] state_q;

  int errors = 0;
  int checks = 0;

  demux_pair_capture #(.W(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .sel        (sel),
    .din_valid  (din_valid),
    .pair_ack   (pair_ack),
    .ovr_clr    (ovr_clr),
    .x_q        (x_q),
    .y_q        (y_q),
    .pair_valid (pair_valid),
    .overrun    (overrun),
    .pair_count (pair_count),
    .state_q    (state_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one cycle of stimulus, then return all qualifiers low.
  task automatic drive(input logic v, input logic s, input logic [7:0] d,
                       input logic ack, input logic clr);
    din_valid = v; sel = s; din = d; pair_ack = ack; ovr_clr = clr;
    step();
    din_valid = 1'b0; pair_ack = 1'b0; ovr_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = '0; sel = 1'b0; din_valid = 1'b0; pair_ack = 1'b0; ovr_clr = 1'b0;
    #2;
    checks++;
    if ({x_q, y_q, pair_valid, overrun, pair_count, state_q} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs: got x=%h y=%h pv=%b ovr=%b cnt=%h st=%0d, want all 0",
               x_q, y_q, pair_valid, overrun, pair_count, state_q);
    end
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if (state_q !== 2'd0) begin
      errors++; $display("FAIL reset_idle: state=%0d want 0", state_q);
    end
  endtask

  task automatic test_pair_capture();
    drive(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
    checks++;
    if (state_q !== 2'd1 || x_q !== 8'h3C || pair_valid !== 1'b0) begin
      errors++; $display("FAIL cap_x: st=%0d x=%h pv=%b want 1 3c 0", state_q, x_q, pair_valid);
    end
    drive(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    checks++;
    if (state_q !== 2'd3 || pair_valid !== 1'b1 || x_q !== 8'h3C || y_q !== 8'hA5 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL pair_ready: st=%0d pv=%b x=%h y=%h ovr=%b want 3 1 3c a5 0",
               state_q, pair_valid, x_q, y_q, overrun);
    end
  endtask

  task automatic test_ack();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (state_q !== 2'd0 || pair_valid !== 1'b0 || pair_count !== 8'd1 || x_q !== 8'h3C || y_q !== 8'hA5) begin
      errors++;
      $display("FAIL ack: st=%0d pv=%b cnt=%0d x=%h y=%h want 0 0 1 3c a5",
               state_q, pair_valid, pair_count, x_q, y_q);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (state_q !== 2'd0 || pair_count !== 8'd1) begin
      errors++; $display("FAIL ack_ignored: st=%0d cnt=%0d want 0 1", state_q, pair_count);
    end
  endtask

  task automatic test_overwrite();
    drive(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    checks++;
    if (state_q !== 2'd2 || y_q !== 8'h11 || overrun !== 1'b0) begin
      errors++; $display("FAIL first_y: st=%0d y=%h ovr=%b want 2 11 0", state_q, y_q, overrun);
    end
    drive(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
    checks++;
    if (state_q !== 2'd2 || y_q !== 8'h22 || overrun !== 1'b1) begin
      errors++; $display("FAIL y_overwrite: st=%0d y=%h ovr=%b want 2 22 1", state_q, y_q, overrun);
    end
    drive(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    checks++;
    if (state_q !== 2'd3 || pair_valid !== 1'b1 || x_q !== 8'h33 || y_q !== 8'h22) begin
      errors++;
      $display("FAIL pair_after_ovr: st=%0d pv=%b x=%h y=%h want 3 1 33 22", state_q, pair_valid, x_q, y_q);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (overrun !== 1'b0 || state_q !== 2'd3) begin
      errors++; $display("FAIL ovr_clr: ovr=%b st=%0d want 0 3", overrun, state_q);
    end
  endtask

  task automatic test_pair_drop();
    drive(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    checks++;
    if (state_q !== 2'd3 || x_q !== 8'h33 || overrun !== 1'b1 || pair_valid !== 1'b1) begin
      errors++;
      $display("FAIL pair_drop: st=%0d x=%h ovr=%b pv=%b want 3 33 1 1", state_q, x_q, overrun, pair_valid);
    end
    drive(1'b1, 1'b0, 8'h66, 1'b1, 1'b0);
    checks++;
    if (state_q !== 2'd1 || x_q !== 8'h66 || pair_count !== 8'd2 || pair_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_with_word: st=%0d x=%h cnt=%0d pv=%b want 1 66 2 0", state_q, x_q, pair_count, pair_valid);
    end
  endtask

  task automatic test_count_wrap();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 252; i++) begin
      drive(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
      drive(1'b1, 1'b1, 8'(i + 1), 1'b0, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++;
    if (pair_count !== 8'hFF || overrun !== 1'b0) begin
      errors++; $display("FAIL count_ff: cnt=%h ovr=%b want ff 0", pair_count, overrun);
    end
    drive(1'b1, 1'b0, 8'hA0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'hB0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (pair_count !== 8'h00 || state_q !== 2'd0) begin
      errors++; $display("FAIL count_wrap: cnt=%h st=%0d want 00 0", pair_count, state_q);
    end
    drive(1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h02, 1'b0, 1'b1);
    checks++;
    if (overrun !== 1'b1 || x_q !== 8'h02 || state_q !== 2'd1) begin
      errors++; $display("FAIL set_beats_clr: ovr=%b x=%h st=%0d want 1 02 1", overrun, x_q, state_q);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
    checks++;
    if (state_q !== 2'd1 || x_q !== 8'h44) begin
      errors++; $display("FAIL pre_reset_x: st=%0d x=%h want 1 44", state_q, x_q);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({x_q, y_q, pair_valid, overrun, pair_count, state_q} !== 28'd0) begin
      errors++;
      $display("FAIL async_reset: x=%h y=%h pv=%b ovr=%b cnt=%h st=%0d want all 0",
               x_q, y_q, pair_valid, overrun, pair_count, state_q);
    end
    #2 rst = 1'b0;
    step();
    drive(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    checks++;
    if (state_q !== 2'd2 || pair_valid !== 1'b0 || y_q !== 8'h99 || x_q !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_y: st=%0d pv=%b y=%h x=%h want 2 0 99 00", state_q, pair_valid, y_q, x_q);
    end
  endtask

  initial begin
    test_reset();
    test_pair_capture();
    test_ack();
    test_overwrite();
    test_pair_drop();
    test_count_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
